// File: rtl/pixel_writer.sv
// pixel_writer: turns base + offset coordinate requests into pixel writes.
// It clips them to the visible screen, queues them in a small FIFO and
// presents them to a VGA-style sink one pixel per cycle.
//
// Ports:
//   clock, resetn             single clock, synchronous active-low reset
//   ld_xy/ld_pos/ld_colour    load base x/y, offset dx/dy, colour registers
//   x, y, dx, dy, colour      values for the loads above (9 bits each)
//   draw_pixel                request one pixel at (xb+dxr, yb+dyr) in col
//   clear                     flush all queued pixels at the next edge
//   vga_ready                 sink accepts a pixel this cycle
//   vga_x/vga_y/vga_colour    registered pixel presented to the sink
//   vga_plot                  one-cycle write strobe per pixel
//   idle                      nothing queued and no strobe in progress
//   overflow                  sticky: a pixel was dropped on a full FIFO
//   pixel_count               saturating count of strobes since reset
module pixel_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int DEPTH    = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ld_xy,
  input  logic        ld_pos,
  input  logic        ld_colour,
  input  logic        draw_pixel,
  input  logic [8:0]  x,
  input  logic [8:0]  y,
  input  logic [8:0]  dx,
  input  logic [8:0]  dy,
  input  logic [8:0]  colour,
  input  logic        clear,
  input  logic        vga_ready,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [8:0]  vga_colour,
  output logic        vga_plot,
  output logic        idle,
  output logic        overflow,
  output logic [15:0] pixel_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 26;  // {x[8:0], y[7:0], colour[8:0]}
  localparam logic [9:0]    SCREEN_W_C = 10'(SCREEN_W);
  localparam logic [9:0]    SCREEN_H_C = 10'(SCREEN_H);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

  logic [8:0]    xb_r, yb_r, dxr_r, dyr_r, col_r;
  logic [EW-1:0] fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [8:0]    vga_x_r, vga_colour_r;
  logic [7:0]    vga_y_r;
  logic          vga_plot_r, overflow_r;
  logic [15:0]   pixel_count_r;

  logic [9:0]    px_s, py_s;
  logic          clip_s, full_s, pop_s, push_req_s, push_s, drop_s;
  logic [EW-1:0] entry_s;

  // Coordinate sum, clipping and FIFO handshake decode.
  always_comb begin
    // Sums kept at 10 bits so large offsets cannot wrap back on screen.
    px_s       = {1'b0, xb_r} + {1'b0, dxr_r};
    py_s       = {1'b0, yb_r} + {1'b0, dyr_r};
    clip_s     = (px_s >= SCREEN_W_C) || (py_s >= SCREEN_H_C);
    entry_s    = {px_s[8:0], py_s[7:0], col_r};
    full_s     = (count_r == DEPTH_C);
    pop_s      = (count_r != {CW{1'b0}}) && vga_ready;
    // A clear discards a same-cycle request; a pop frees room for a push.
    push_req_s = draw_pixel && !clip_s && !clear;
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
  end

  // Coordinate and colour registers; loads are independent.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      xb_r  <= 9'd0;
      yb_r  <= 9'd0;
      dxr_r <= 9'd0;
      dyr_r <= 9'd0;
      col_r <= 9'd0;
    end else begin
      if (ld_xy) begin
        xb_r <= x;
        yb_r <= y;
      end
      if (ld_pos) begin
        dxr_r <= dx;
        dyr_r <= dy;
      end
      if (ld_colour) begin
        col_r <= colour;
      end
    end
  end

  // FIFO storage; contents need no reset because pointers gate them.
  always_ff @(posedge clock) begin
    if (resetn && push_s) begin
      fifo_mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output stage: a pop in the clear cycle still produces its strobe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vga_x_r      <= 9'd0;
      vga_y_r      <= 8'd0;
      vga_colour_r <= 9'd0;
      vga_plot_r   <= 1'b0;
    end else if (pop_s) begin
      vga_x_r      <= fifo_mem_r[rd_ptr_r][25:17];
      vga_y_r      <= fifo_mem_r[rd_ptr_r][16:9];
      vga_colour_r <= fifo_mem_r[rd_ptr_r][8:0];
      vga_plot_r   <= 1'b1;
    end else begin
      vga_plot_r   <= 1'b0;
    end
  end

  // Sticky overflow flag and saturating plot counter.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      overflow_r    <= 1'b0;
      pixel_count_r <= 16'd0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (vga_plot_r && (pixel_count_r != 16'hFFFF)) begin
        pixel_count_r <= pixel_count_r + 16'd1;
      end
    end
  end

  assign vga_x       = vga_x_r;
  assign vga_y       = vga_y_r;
  assign vga_colour  = vga_colour_r;
  assign vga_plot    = vga_plot_r;
  assign overflow    = overflow_r;
  assign pixel_count = pixel_count_r;
  assign idle        = (count_r == {CW{1'b0}}) && !vga_plot_r;

endmodule
